// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divider derivation
//
// Purpose : common definitions for the one-byte UART receiver and its
//           transmitter counterpart.
// Contents: uart_rx_state_e - receiver state encoding
//           UART_DATA_BITS  - data bits per frame (8N1)
//           uart_tick_div() - clocks per oversample tick (integer truncation)

package uart_pkg;

  typedef enum logic [1:0] {
    UART_RX_IDLE  = 2'd0,
    UART_RX_START = 2'd1,
    UART_RX_DATA  = 2'd2,
    UART_RX_STOP  = 2'd3
  } uart_rx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick. Truncates, so the real bit rate is never
  // slower than requested; callers must keep the result >= 1.
  function automatic int uart_tick_div(input int clk_freq,
                                       input int baud_rate,
                                       input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - free-running divider producing a one-clock tick
//
// Purpose : divides the system clock by TICK_DIV; o_tick is high while the
//           counter sits at its last value. A synchronous clear restarts the
//           count so a receiver can phase-align to a start edge.
// Ports   : i_clk  - system clock (rising edge)
//           i_rst  - synchronous active-high reset
//           i_clr  - synchronous clear of the divider count
//           o_tick - combinational tick, high when count == TICK_DIV-1

module uart_baud_tick_gen #(
  parameter int TICK_DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_div_cnt;

  assign o_tick = (r_div_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_div_cnt <= '0;
    end else if (o_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/one_byte_uart_rx.sv
// rtl/one_byte_uart_rx.sv - oversampling 8N1 UART receiver for a single byte
//
// Purpose : recovers one 8N1 frame from an asynchronous serial line, re-aligns
//           its sample phase on every start edge, rejects glitch starts and
//           flags framing errors.
// Macro   : UART_RX_MAJORITY_EN - when defined, every bit is the 2-of-3 vote of
//           the samples at s = M-1, M, M+1 (decision at M+1); otherwise the
//           single sample at s = M is used (decision at M).
// Ports   : i_clk       - system clock (rising edge)
//           i_rst       - synchronous active-high reset
//           i_rx_in     - asynchronous serial input, idles high
//           o_rx_data   - last correctly framed byte, held until the next one
//           o_rx_valid  - one-clock pulse when o_rx_data is updated
//           o_frame_err - one-clock pulse when the stop bit is sampled low
//           o_rx_busy   - high in every state except IDLE

module one_byte_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx_in,
  output logic [UART_DATA_BITS-1:0] o_rx_data,
  output logic                      o_rx_valid,
  output logic                      o_frame_err,
  output logic                      o_rx_busy
);

  localparam int TICK_DIV = uart_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(UART_DATA_BITS);

  localparam logic [SW-1:0] LP_S_LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] LP_S_EARLY = SW'(M - 1);
  localparam logic [SW-1:0] LP_S_MID   = SW'(M);
  localparam logic [SW-1:0] LP_S_DEC   = SW'(M + 1);
`else
  localparam logic [SW-1:0] LP_S_DEC   = SW'(M);
`endif
  localparam logic [BW-1:0] LP_BIT_LAST = BW'(UART_DATA_BITS - 1);

  // Registers
  logic                      r_sync1;
  logic                      r_sync2;
  logic                      r_sync_d;
  uart_rx_state_e            r_state;
  logic [SW-1:0]             r_s;
  logic [BW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_err;
`ifdef UART_RX_MAJORITY_EN
  logic                      r_samp_early;
  logic                      r_samp_mid;
`endif

  // Combinational signals
  uart_rx_state_e w_state_next;
  logic           w_tick;
  logic           w_fall;
  logic           w_dec_tick;
  logic           w_wrap;
  logic           w_bit_val;
  logic           w_clr;
  logic           w_bit_clr;
  logic           w_bit_inc;
  logic           w_shift_en;
  logic           w_load;
  logic           w_set_valid;
  logic           w_set_ferr;

  uart_baud_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Edge seen on the synchronised line only, so metastability never reaches
  // the state machine.
  assign w_fall     = r_sync_d & ~r_sync2;
  assign w_dec_tick = w_tick && (r_s == LP_S_DEC);
  assign w_wrap     = w_tick && (r_s == LP_S_LAST);

`ifdef UART_RX_MAJORITY_EN
  // The third vote is the live synchronised sample at tick M+1.
  assign w_bit_val = (r_samp_early & r_samp_mid) |
                     (r_samp_early & r_sync2)    |
                     (r_samp_mid   & r_sync2);
`else
  assign w_bit_val = r_sync2;
`endif

  // Synchroniser and edge register; idle-high reset avoids a false edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= i_rx_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= UART_RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
    w_set_valid  = 1'b0;
    w_set_ferr   = 1'b0;

    case (r_state)
      UART_RX_IDLE: begin
        if (w_fall) begin
          w_clr        = 1'b1;
          w_bit_clr    = 1'b1;
          w_state_next = UART_RX_START;
        end
      end

      UART_RX_START: begin
        if (w_dec_tick && w_bit_val) begin
          // Line was high again at mid-bit: a glitch, not a start bit.
          w_state_next = UART_RX_IDLE;
        end else if (w_wrap) begin
          w_state_next = UART_RX_DATA;
        end
      end

      UART_RX_DATA: begin
        if (w_dec_tick) begin
          w_shift_en = 1'b1;
        end
        if (w_wrap) begin
          if (r_bit_idx == LP_BIT_LAST) begin
            w_state_next = UART_RX_STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end

      UART_RX_STOP: begin
        // Leave at mid-stop so a following start edge can be caught.
        if (w_dec_tick) begin
          if (w_bit_val) begin
            w_load      = 1'b1;
            w_set_valid = 1'b1;
          end else begin
            w_set_ferr  = 1'b1;
          end
          w_state_next = UART_RX_IDLE;
        end
      end

      default: begin
        w_state_next = UART_RX_IDLE;
      end
    endcase
  end

  // Sample counter, bit index, shift register and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s         <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_clr) begin
        r_s <= '0;
      end else if (w_tick && (r_state != UART_RX_IDLE)) begin
        r_s <= (r_s == LP_S_LAST) ? '0 : r_s + SW'(1);
      end

      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_bit_inc) begin
        r_bit_idx <= r_bit_idx + BW'(1);
      end

      // LSB arrives first, so shift right and insert at the MSB.
      if (w_shift_en) begin
        r_shift <= {w_bit_val, r_shift[UART_DATA_BITS-1:1]};
      end

      if (w_load) begin
        r_rx_data <= r_shift;
      end

      r_rx_valid  <= w_set_valid;
      r_frame_err <= w_set_ferr;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Capture the two early votes; the late vote is taken live.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_samp_early <= 1'b1;
      r_samp_mid   <= 1'b1;
    end else if (w_tick && (r_state != UART_RX_IDLE)) begin
      if (r_s == LP_S_EARLY) begin
        r_samp_early <= r_sync2;
      end
      if (r_s == LP_S_MID) begin
        r_samp_mid <= r_sync2;
      end
    end
  end
`endif

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;
  assign o_rx_busy   = (r_state != UART_RX_IDLE);

endmodule

// File: tb/tb_one_byte_uart_rx.sv
// tb/tb_one_byte_uart_rx.sv - directed self-checking bench for one_byte_uart_rx

module tb_one_byte_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT      = 157;
  localparam logic [7:0] MAJ_EXP = 8'h81;
`else
  localparam int LAT      = 156;
  localparam logic [7:0] MAJ_EXP = 8'h85;
`endif

  one_byte_uart_rx #(
    .CLK_FREQ   (1600),
    .BAUD_RATE  (100),
    .OVERSAMPLE (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_in     (rx_in),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_frame_err (frame_err),
    .o_rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records pulse events, sampled on the falling edge.
  int         valid_rises = 0;
  int         valid_cycles = 0;
  int         ferr_rises = 0;
  int         ferr_cycles = 0;
  int         both_seen = 0;
  int         busy_cycles = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_busy = 1'b0;
  logic       busy_at_valid = 1'b1;
  logic       busy_before_valid = 1'b0;
  logic [7:0] data_q[$];
  int         valid_cyc_q[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cycles++;
      if (prev_valid !== 1'b1) begin
        valid_rises++;
        data_q.push_back(rx_data);
        valid_cyc_q.push_back(cyc);
        busy_at_valid     = rx_busy;
        busy_before_valid = prev_busy;
      end
    end
    if (frame_err === 1'b1) begin
      ferr_cycles++;
      if (prev_ferr !== 1'b1) ferr_rises++;
    end
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_seen++;
    if (rx_busy === 1'b1) busy_cycles++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_busy  = rx_busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Drives one frame, 16 clocks per bit. flip_n/flip_off invert one clock of
  // line bit flip_n (0 = start). abort_n aborts with a 1-clock reset at the
  // start of offset abort_off of line bit abort_n.
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int flip_n, input int flip_off,
                            input int abort_n, input int abort_off,
                            output int start_cyc);
    logic b;
    start_cyc = -1;
    for (int n = 0; n < 10; n++) begin
      if (n == 0)      b = 1'b0;
      else if (n == 9) b = stop_val;
      else             b = d[n-1];
      for (int off = 0; off < 16; off++) begin
        @(negedge clk);
        if (start_cyc < 0) start_cyc = cyc;
        if (n == abort_n && off == abort_off) begin
          rx_in = 1'b1;
          rst   = 1'b1;
          @(negedge clk);
          rst   = 1'b0;
          return;
        end
        rx_in = (n == flip_n && off == flip_off) ? ~b : b;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_framing_error;
    int v0, f0, fc0, b0, sc;
    v0 = valid_rises; f0 = ferr_rises; fc0 = ferr_cycles;
    send_frame(8'h3C, 1'b0, -1, 0, -1, 0, sc);
    repeat (4) @(negedge clk);
    checks++; if (ferr_rises - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", ferr_rises - f0); end
    checks++; if (ferr_cycles - fc0 !== 1) begin errors++; $display("FAIL ferr_width got %0d want 1", ferr_cycles - fc0); end
    checks++; if (valid_rises - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", valid_rises - v0); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ferr_data_held got %h want 00", rx_data); end
    // Line stays low: the receiver must not re-arm.
    b0 = busy_cycles;
    repeat (40) @(negedge clk);
    checks++; if (busy_cycles - b0 !== 0) begin errors++; $display("FAIL ferr_no_rearm busy_cycles got %0d want 0", busy_cycles - b0); end
    idle(10);
    v0 = valid_rises;
    send_frame(8'h3C, 1'b1, -1, 0, -1, 0, sc);
    idle(4);
    checks++; if (valid_rises - v0 !== 1) begin errors++; $display("FAIL rearm_valid got %0d want 1", valid_rises - v0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rearm_data got %h want 3c", rx_data); end
  endtask

  task automatic test_good_frame;
    int v0, vc0, f0, sc;
    v0 = valid_rises; vc0 = valid_cycles; f0 = ferr_rises;
    send_frame(8'hA5, 1'b1, -1, 0, -1, 0, sc);
    idle(4);
    checks++; if (valid_rises - v0 !== 1) begin errors++; $display("FAIL good_valid_pulses got %0d want 1", valid_rises - v0); end
    checks++; if (valid_cycles - vc0 !== 1) begin errors++; $display("FAIL good_valid_width got %0d want 1", valid_cycles - vc0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", rx_data); end
    checks++; if (ferr_rises - f0 !== 0) begin errors++; $display("FAIL good_no_ferr got %0d want 0", ferr_rises - f0); end
    checks++; if (busy_at_valid !== 1'b0 || busy_before_valid !== 1'b1) begin errors++; $display("FAIL good_busy_fall got at=%b before=%b want at=0 before=1", busy_at_valid, busy_before_valid); end
    checks++; if (valid_cyc_q[$] - sc !== LAT) begin errors++; $display("FAIL good_latency got %0d want %0d", valid_cyc_q[$] - sc, LAT); end
  endtask

  task automatic test_back_to_back;
    int v0, sc;
    v0 = valid_rises;
    send_frame(8'h00, 1'b1, -1, 0, -1, 0, sc);
    send_frame(8'hFF, 1'b1, -1, 0, -1, 0, sc);
    idle(4);
    checks++; if (valid_rises - v0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", valid_rises - v0); end
    checks++; if (data_q[$-1] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", data_q[$-1]); end
    checks++; if (data_q[$] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", data_q[$]); end
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    v0 = valid_rises; f0 = ferr_rises; b0 = busy_cycles;
    repeat (4) begin @(negedge clk); rx_in = 1'b0; end
    idle(12);
    checks++; if (busy_cycles - b0 <= 0) begin errors++; $display("FAIL glitch_busy_seen got %0d want >0", busy_cycles - b0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", rx_busy); end
    idle(30);
    checks++; if (valid_rises - v0 !== 0 || ferr_rises - f0 !== 0) begin errors++; $display("FAIL glitch_no_pulse got valid=%0d ferr=%0d want 0 0", valid_rises - v0, ferr_rises - f0); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL glitch_data_held got %h want ff", rx_data); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, sc;
    send_frame(8'hC3, 1'b1, -1, 0, 5, 4, sc);
    checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs got data=%h v=%b fe=%b busy=%b want 00 0 0 0", rx_data, rx_valid, frame_err, rx_busy); end
    v0 = valid_rises; f0 = ferr_rises;
    idle(30);
    checks++; if (valid_rises - v0 !== 0 || ferr_rises - f0 !== 0) begin errors++; $display("FAIL midrst_no_pulse got valid=%0d ferr=%0d want 0 0", valid_rises - v0, ferr_rises - f0); end
    send_frame(8'h5A, 1'b1, -1, 0, -1, 0, sc);
    idle(4);
    checks++; if (valid_rises - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid got %0d want 1", valid_rises - v0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL midrst_next_data got %h want 5a", rx_data); end
  endtask

  task automatic test_majority;
    int v0, sc;
    v0 = valid_rises;
    // Data bit 2 is line bit 3; DUT s=M sample is line offset 9.
    send_frame(8'h81, 1'b1, 3, 9, -1, 0, sc);
    idle(4);
    checks++; if (valid_rises - v0 !== 1) begin errors++; $display("FAIL maj_valid got %0d want 1", valid_rises - v0); end
    checks++; if (rx_data !== MAJ_EXP) begin errors++; $display("FAIL maj_data got %h want %h", rx_data, MAJ_EXP); end
  endtask

  task automatic test_exclusion;
    checks++; if (both_seen !== 0) begin errors++; $display("FAIL valid_ferr_exclusive got %0d want 0", both_seen); end
  endtask

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    test_reset();
    test_framing_error();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    test_majority();
    test_exclusion();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
